// File: rtl/vdic_dut_pkg.sv
// Shared types for the result checker: command codes, FSM state
// encoding and a small command-validity helper.
package vdic_dut_pkg;

    typedef enum logic [7:0] {
        NOP = 8'h00,
        AND = 8'h01,
        OR  = 8'h02,
        XOR = 8'h03,
        ADD = 8'h10,
        SUB = 8'h20
    } command_t;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_ACCUM = 1'b1;

    function automatic logic cmd_known(input logic [7:0] c);
        case (c)
            NOP, AND, OR, XOR, ADD, SUB: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vdic_sync_fifo.sv
// Synchronous FIFO holding expected results. A push and a pop in the
// same cycle both succeed, even when the FIFO is full.
module vdic_sync_fifo
    import vdic_dut_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vdic_result_checker.sv
// Result checker: accumulates operand packets into expected values,
// queues them and compares against DUT results with sticky error flags.
module vdic_result_checker
    import vdic_dut_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [7:0]        in_cmd,
    input  logic [DW-1:0]     in_data,
    input  logic              out_valid,
    input  logic [2*DW-1:0]   out_data,
    input  logic              clr,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              mismatch,
    output logic [2*DW-1:0]   last_expected,
    output logic [2*DW-1:0]   last_received,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic              timeout_err,
    output logic              proto_err,
    output logic              cmd_err,
    output logic              busy
);

    localparam int RW = 2 * DW;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [RW-1:0]   din, exp_val, head;
    logic            push, pop, full, empty;
    logic            proto_set, cmd_set, ovf_set, und_set;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic            mis_q, mis_d;
    logic [RW-1:0]   lexp_q, lexp_d, lrcv_q, lrcv_d;
    logic [4:0]      flg_q, flg_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    assign din     = {{DW{1'b0}}, in_data};
    assign pop     = out_valid && !empty;
    assign und_set = out_valid && empty;
    assign ovf_set = push && full && !pop;

    // Packet accumulation FSM and expected-value generation.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cmd_d     = cmd_q;
        push      = 1'b0;
        proto_set = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                proto_set = (state_q == ST_ACCUM);
                cmd_d     = in_cmd;
                acc_d     = (in_cmd == NOP) ? '0 : din;
                push      = in_eop;
                state_d   = in_eop ? ST_IDLE : ST_ACCUM;
            end else if (state_q == ST_ACCUM) begin
                case (cmd_q)
                    ADD:     acc_d = acc_q + din;
                    SUB:     acc_d = acc_q - din;
                    AND:     acc_d = acc_q & din;
                    OR:      acc_d = acc_q | din;
                    XOR:     acc_d = acc_q ^ din;
                    NOP:     acc_d = '0;
                    default: acc_d = acc_q;
                endcase
                push    = in_eop;
                state_d = in_eop ? ST_IDLE : ST_ACCUM;
            end else begin
                proto_set = 1'b1;
            end
        end
        exp_val = cmd_known(cmd_d) ? acc_d : '1;
        cmd_set = push && !cmd_known(cmd_d);
    end

    // Accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cmd_q   <= cmd_d;
        end
    end

    vdic_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (exp_val),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Compare results, saturating counters, sticky flags and timeout.
    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        mis_d  = 1'b0;
        lexp_d = lexp_q;
        lrcv_d = lrcv_q;
        flg_d  = flg_q;
        tmo_d  = tmo_q;
        if (clr) begin
            pass_d = '0;
            fail_d = '0;
            flg_d  = '0;
            tmo_d  = '0;
        end else begin
            if (pop) begin
                lexp_d = head;
                lrcv_d = out_data;
                if (head == out_data) begin
                    if (pass_q != '1) pass_d = pass_q + 1'b1;
                end else begin
                    mis_d = 1'b1;
                    if (fail_q != '1) fail_d = fail_q + 1'b1;
                end
            end
            if (und_set && fail_q != '1) fail_d = fail_q + 1'b1;
            if (empty || out_valid) begin
                tmo_d = '0;
            end else if (tmo_q != TW'(TIMEOUT)) begin
                tmo_d = tmo_q + 1'b1;
            end
            flg_d = flg_q | {ovf_set, und_set,
                             tmo_d == TW'(TIMEOUT),
                             proto_set, cmd_set};
        end
    end

    // Result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            fail_q <= '0;
            mis_q  <= 1'b0;
            lexp_q <= '0;
            lrcv_q <= '0;
            flg_q  <= '0;
            tmo_q  <= '0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            mis_q  <= mis_d;
            lexp_q <= lexp_d;
            lrcv_q <= lrcv_d;
            flg_q  <= flg_d;
            tmo_q  <= tmo_d;
        end
    end

    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign mismatch      = mis_q;
    assign last_expected = lexp_q;
    assign last_received = lrcv_q;
    assign overflow_err  = flg_q[4];
    assign underflow_err = flg_q[3];
    assign timeout_err   = flg_q[2];
    assign proto_err     = flg_q[1];
    assign cmd_err       = flg_q[0];
    assign busy          = (state_q == ST_ACCUM) || !empty;

endmodule

// File: tb/tb_vdic_result_checker.sv
// Bench for vdic_result_checker: directed scenarios plus a randomized
// run against a packet-level reference model and scoreboard queue.
module tb_vdic_result_checker;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_sop = 0, in_eop = 0;
    logic [7:0]  in_cmd = 0, in_data = 0;
    logic        out_valid = 0;
    logic [15:0] out_data = 0;
    logic        clr = 0;
    logic [3:0]  pass_cnt, fail_cnt;
    logic        mismatch;
    logic [15:0] last_expected, last_received;
    logic        overflow_err, underflow_err, timeout_err;
    logic        proto_err, cmd_err, busy;
    logic [4:0]  flags;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] pkt_d [4];
    logic [7:0] cmd_tbl [7] = '{8'h00, 8'h01, 8'h02, 8'h03,
                                8'h10, 8'h20, 8'h5A};

    assign flags = {overflow_err, underflow_err, timeout_err,
                    proto_err, cmd_err};

    vdic_result_checker #(
        .DW(8), .DEPTH(4), .CNT_W(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_cmd(in_cmd), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .clr(clr),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch(mismatch),
        .last_expected(last_expected), .last_received(last_received),
        .overflow_err(overflow_err), .underflow_err(underflow_err),
        .timeout_err(timeout_err), .proto_err(proto_err),
        .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Packet-level reference: fold operands with the command's operator.
    function automatic logic [15:0] model(input logic [7:0] cmd,
                                          input int n);
        logic [15:0] a;
        a = {8'h00, pkt_d[0]};
        if (cmd == 8'h00) return 16'h0000;
        if (!(cmd inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h20}))
            return 16'hFFFF;
        for (int i = 1; i < n; i++) begin
            case (cmd)
                8'h01:   a = a & {8'h00, pkt_d[i]};
                8'h02:   a = a | {8'h00, pkt_d[i]};
                8'h03:   a = a ^ {8'h00, pkt_d[i]};
                8'h10:   a = a + {8'h00, pkt_d[i]};
                default: a = a - {8'h00, pkt_d[i]};
            endcase
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sop, input logic eop,
                        input logic [7:0] cmd, input logic [7:0] d);
        in_valid = 1; in_sop = sop; in_eop = eop;
        in_cmd = cmd; in_data = d;
        tick();
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input int n);
        for (int i = 0; i < n; i++)
            beat(i == 0, i == n - 1, cmd, pkt_d[i]);
    endtask

    task automatic ret(input logic [15:0] v);
        out_valid = 1; out_data = v;
        tick();
        out_valid = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic set_pkt(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        pkt_d[0] = a; pkt_d[1] = b; pkt_d[2] = c; pkt_d[3] = d;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) tick();
        n_vec++; if ({pass_cnt, fail_cnt} !== 8'h00) begin n_err++;
            $display("FAIL reset_cnt got %h exp 00", {pass_cnt, fail_cnt}); end
        n_vec++; if ({flags, mismatch, busy} !== 7'h00) begin n_err++;
            $display("FAIL reset_flags got %b exp 0", {flags, mismatch, busy}); end
        n_vec++; if ({last_expected, last_received} !== 32'h0) begin n_err++;
            $display("FAIL reset_last got %h exp 0", {last_expected, last_received}); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_add();
        set_pkt(8'hFF, 8'hFF, 8'h02, 8'h00);
        send_pkt(8'h10, 3);
        n_vec++; if (busy !== 1'b1) begin n_err++;
            $display("FAIL add_busy got %b exp 1", busy); end
        ret(16'h0200);
        n_vec++; if (pass_cnt !== 4'd1 || mismatch !== 1'b0) begin n_err++;
            $display("FAIL add_pass got %0d/%b exp 1/0", pass_cnt, mismatch); end
        n_vec++; if (last_expected !== 16'h0200) begin n_err++;
            $display("FAIL add_lexp got %h exp 0200", last_expected); end
    endtask

    task automatic test_sub();
        do_clr();
        set_pkt(8'h01, 8'h02, 8'h00, 8'h00);
        send_pkt(8'h20, 2);
        ret(16'h0000);
        n_vec++; if (mismatch !== 1'b1 || fail_cnt !== 4'd1) begin n_err++;
            $display("FAIL sub_mis got %b/%0d exp 1/1", mismatch, fail_cnt); end
        n_vec++; if (last_expected !== 16'hFFFF || last_received !== 16'h0) begin
            n_err++;
            $display("FAIL sub_last got %h/%h exp FFFF/0000",
                     last_expected, last_received); end
        tick();
        n_vec++; if (mismatch !== 1'b0) begin n_err++;
            $display("FAIL sub_pulse got %b exp 0", mismatch); end
    endtask

    task automatic test_overflow();
        do_clr();
        set_pkt(8'hF0, 8'h3C, 8'h00, 8'h00); send_pkt(8'h01, 2);
        set_pkt(8'hF0, 8'h0F, 8'h00, 8'h00); send_pkt(8'h02, 2);
        set_pkt(8'hFF, 8'h0F, 8'h00, 8'h00); send_pkt(8'h03, 2);
        set_pkt(8'h55, 8'h00, 8'h00, 8'h00); send_pkt(8'h00, 1);
        n_vec++; if (overflow_err !== 1'b0) begin n_err++;
            $display("FAIL ovf_early got %b exp 0", overflow_err); end
        set_pkt(8'h01, 8'h02, 8'h00, 8'h00); send_pkt(8'h10, 2);
        n_vec++; if (overflow_err !== 1'b1) begin n_err++;
            $display("FAIL ovf_flag got %b exp 1", overflow_err); end
        ret(16'h0030); ret(16'h00FF); ret(16'h00F0); ret(16'h0000);
        n_vec++; if (pass_cnt !== 4'd4 || fail_cnt !== 4'd0) begin n_err++;
            $display("FAIL ovf_pass got %0d/%0d exp 4/0", pass_cnt, fail_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL ovf_busy got %b exp 0", busy); end
    endtask

    task automatic test_underflow();
        do_clr();
        ret(16'h1234);
        n_vec++; if (underflow_err !== 1'b1 || fail_cnt !== 4'd1) begin n_err++;
            $display("FAIL und got %b/%0d exp 1/1", underflow_err, fail_cnt); end
        n_vec++; if (mismatch !== 1'b0 || pass_cnt !== 4'd0) begin n_err++;
            $display("FAIL und_mis got %b/%0d exp 0/0", mismatch, pass_cnt); end
    endtask

    task automatic test_timeout();
        do_clr();
        set_pkt(8'h01, 8'h02, 8'h00, 8'h00);
        send_pkt(8'h10, 2);
        repeat (15) tick();
        n_vec++; if (timeout_err !== 1'b0) begin n_err++;
            $display("FAIL tmo_early got %b exp 0", timeout_err); end
        tick();
        n_vec++; if (timeout_err !== 1'b1) begin n_err++;
            $display("FAIL tmo_set got %b exp 1", timeout_err); end
        ret(16'h0003);
        set_pkt(8'hAA, 8'h00, 8'h00, 8'h00);
        send_pkt(8'h00, 1);
        ret(16'h0000);
        n_vec++; if (pass_cnt !== 4'd2 || mismatch !== 1'b0) begin n_err++;
            $display("FAIL tmo_nop got %0d/%b exp 2/0", pass_cnt, mismatch); end
    endtask

    task automatic test_proto_cmd();
        do_clr();
        beat(1'b0, 1'b0, 8'h10, 8'h05);
        n_vec++; if (proto_err !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL proto_idle got %b/%b exp 1/0", proto_err, busy); end
        do_clr();
        beat(1'b1, 1'b1, 8'h77, 8'h03);
        n_vec++; if (cmd_err !== 1'b1 || proto_err !== 1'b0) begin n_err++;
            $display("FAIL cmd_err got %b/%b exp 1/0", cmd_err, proto_err); end
        ret(16'hFFFF);
        n_vec++; if (pass_cnt !== 4'd1) begin n_err++;
            $display("FAIL cmd_ones got %0d exp 1", pass_cnt); end
        do_clr();
        beat(1'b1, 1'b0, 8'h10, 8'h05);
        beat(1'b1, 1'b0, 8'h10, 8'h01);
        n_vec++; if (proto_err !== 1'b1) begin n_err++;
            $display("FAIL proto_accum got %b exp 1", proto_err); end
        beat(1'b0, 1'b1, 8'h10, 8'h02);
        ret(16'h0003);
        n_vec++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin n_err++;
            $display("FAIL restart got %0d/%0d exp 1/0", pass_cnt, fail_cnt); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int i = 1; i <= 4; i++) beat(1'b1, 1'b1, 8'h10, 8'(i));
        in_valid = 1; in_sop = 1; in_eop = 1; in_cmd = 8'h10; in_data = 8'h09;
        out_valid = 1; out_data = 16'h0001;
        tick();
        in_valid = 0; in_sop = 0; in_eop = 0; out_valid = 0;
        n_vec++; if (overflow_err !== 1'b0 || pass_cnt !== 4'd1) begin n_err++;
            $display("FAIL full_pp got %b/%0d exp 0/1", overflow_err, pass_cnt); end
        ret(16'h0002); ret(16'h0003); ret(16'h0004); ret(16'h0009);
        n_vec++; if (pass_cnt !== 4'd5 || busy !== 1'b0) begin n_err++;
            $display("FAIL full_drain got %0d/%b exp 5/0", pass_cnt, busy); end
    endtask

    task automatic test_clr();
        set_pkt(8'h11, 8'h00, 8'h00, 8'h00);
        send_pkt(8'h10, 1);
        clr = 1; out_valid = 1; out_data = 16'h0011;
        tick();
        clr = 0; out_valid = 0;
        n_vec++; if (pass_cnt !== 4'd0 || mismatch !== 1'b0) begin n_err++;
            $display("FAIL clr_prec got %0d/%b exp 0/0", pass_cnt, mismatch); end
        n_vec++; if (flags !== 5'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL clr_flags got %b/%b exp 0/0", flags, busy); end
    endtask

    task automatic test_saturation();
        do_clr();
        for (int i = 0; i < 17; i++) begin
            pkt_d[0] = 8'(i);
            send_pkt(8'h10, 1);
            ret(16'(i));
        end
        n_vec++; if (pass_cnt !== 4'd15) begin n_err++;
            $display("FAIL sat_pass got %0d exp 15", pass_cnt); end
        for (int i = 0; i < 17; i++) ret(16'h0);
        n_vec++; if (fail_cnt !== 4'd15) begin n_err++;
            $display("FAIL sat_fail got %0d exp 15", fail_cnt); end
    endtask

    task automatic test_reset_mid();
        beat(1'b1, 1'b0, 8'h10, 8'h07);
        #2 rst_n = 0;
        #1;
        n_vec++; if ({pass_cnt, fail_cnt, flags, mismatch, busy} !== 15'h0) begin
            n_err++;
            $display("FAIL rst_mid got %h exp 0",
                     {pass_cnt, fail_cnt, flags, mismatch, busy}); end
        n_vec++; if ({last_expected, last_received} !== 32'h0) begin n_err++;
            $display("FAIL rst_last got %h exp 0", {last_expected, last_received}); end
        tick(); tick();
        rst_n = 1;
        tick();
        set_pkt(8'h01, 8'h01, 8'h00, 8'h00);
        send_pkt(8'h10, 2);
        ret(16'h0002);
        n_vec++; if (pass_cnt !== 4'd1 || proto_err !== 1'b0) begin n_err++;
            $display("FAIL rst_after got %0d/%b exp 1/0", pass_cnt, proto_err); end
    endtask

    task automatic test_random();
        logic [15:0] sb [$];
        logic [15:0] e, rcv;
        logic [7:0]  cmd;
        logic        bad, m_ovf;
        int          n, m_pass, m_fail;
        do_clr();
        m_pass = 0; m_fail = 0; m_ovf = 0;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                cmd = cmd_tbl[$urandom_range(0, 6)];
                n = $urandom_range(1, 4);
                for (int i = 0; i < 4; i++) pkt_d[i] = 8'($urandom);
                e = model(cmd, n);
                send_pkt(cmd, n);
                if (sb.size() == 4) m_ovf = 1;
                else sb.push_back(e);
            end
            if ($urandom_range(0, 2) != 0) begin
                if (sb.size() == 0) begin
                    ret(16'($urandom));
                    m_fail = (m_fail == 15) ? 15 : m_fail + 1;
                    n_vec++; if (mismatch !== 1'b0 || underflow_err !== 1'b1) begin
                        n_err++;
                        $display("FAIL rnd_und got %b/%b exp 0/1",
                                 mismatch, underflow_err); end
                end else begin
                    e = sb.pop_front();
                    bad = ($urandom_range(0, 3) == 0);
                    rcv = bad ? (e ^ (16'h1 << $urandom_range(0, 15))) : e;
                    ret(rcv);
                    if (bad) m_fail = (m_fail == 15) ? 15 : m_fail + 1;
                    else m_pass = (m_pass == 15) ? 15 : m_pass + 1;
                    n_vec++; if (mismatch !== bad || last_expected !== e ||
                                 last_received !== rcv) begin
                        n_err++;
                        $display("FAIL rnd_cmp it=%0d got %b/%h/%h exp %b/%h/%h",
                                 it, mismatch, last_expected, last_received,
                                 bad, e, rcv); end
                end
                n_vec++; if (pass_cnt !== 4'(m_pass) || fail_cnt !== 4'(m_fail)) begin
                    n_err++;
                    $display("FAIL rnd_cnt it=%0d got %0d/%0d exp %0d/%0d",
                             it, pass_cnt, fail_cnt, m_pass, m_fail); end
            end
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            ret(e);
            m_pass = (m_pass == 15) ? 15 : m_pass + 1;
        end
        n_vec++; if (pass_cnt !== 4'(m_pass) || overflow_err !== m_ovf) begin
            n_err++;
            $display("FAIL rnd_end got %0d/%b exp %0d/%b",
                     pass_cnt, overflow_err, m_pass, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_underflow();
        test_timeout();
        test_proto_cmd();
        test_back_to_back();
        test_clr();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
